// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the unified-memory arbiter.
//   arb_state_t  : arbiter FSM states
//   REQ_CORE/LOAD: requester ids carried in grant_id
//   LAT_W        : width of the read-latency down-counter (RD_LAT <= 7)
//   STARVE_W     : width of the starvation counter (MAX_WAIT <= 15)
// ---------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } arb_state_t;

  localparam logic REQ_CORE = 1'b0;
  localparam logic REQ_LOAD = 1'b1;

  localparam int LAT_W    = 3;
  localparam int STARVE_W = 4;

endpackage

// File: rtl/mem_arb_select.sv
// ---------------------------------------------------------------------------
// mem_arb_select
// Combinational winner pick for one arbitration slot.
// Default build: the core has priority, but the loader wins once the core
// has been granted MAX_WAIT times in a row while the loader was pending.
// With MEM_ARB_ROUND_ROBIN_EN defined: on contention the port that did not
// own the last transaction wins; the starvation count is ignored.
//
// Ports:
//   c_valid_i    in   core request valid
//   l_valid_i    in   loader request valid
//   starve_cnt_i in   consecutive core wins while loader pending
//   grant_id_i   in   owner of the last transaction
//   win_valid_o  out  some port is requesting
//   win_id_o     out  winning port id (REQ_CORE / REQ_LOAD)
// ---------------------------------------------------------------------------
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic                c_valid_i,
  input  logic                l_valid_i,
  input  logic [STARVE_W-1:0] starve_cnt_i,
  input  logic                grant_id_i,
  output logic                win_valid_o,
  output logic                win_id_o
);

  assign win_valid_o = c_valid_i | l_valid_i;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // Starvation tracking has no role when fairness comes from alternation.
  logic unused_sel;
  assign unused_sel = ^{starve_cnt_i, STARVE_W'(MAX_WAIT)};

  always_comb begin
    win_id_o = REQ_CORE;
    if (c_valid_i && l_valid_i) begin
      win_id_o = ~grant_id_i;
    end else if (l_valid_i) begin
      win_id_o = REQ_LOAD;
    end
  end
`else
  logic unused_sel;
  assign unused_sel = grant_id_i;

  always_comb begin
    win_id_o = REQ_CORE;
    if (l_valid_i && ((starve_cnt_i == STARVE_W'(MAX_WAIT)) || !c_valid_i)) begin
      win_id_o = REQ_LOAD;
    end
  end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares the unified instruction/data memory between the core memory port
// and the program-loader/DMA port, one transaction at a time.
// Optional feature macro: MEM_ARB_ROUND_ROBIN_EN (round-robin on contention,
// see mem_arb_select).
//
//   state  | meaning
//   -------+-------------------------------------------------------------
//   IDLE   | arbitrate; ready to winner; latch payload on transfer
//   ACCESS | one-cycle memory strobe from the latched request
//   WAIT   | read latency down-count; capture m_rdata at count == 1
//   RESP   | one-cycle rsp pulse to the owner, then back to IDLE
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   c_valid/c_we/c_addr/c_wdata  core request;   c_ready accept strobe
//   c_rsp/c_rdata              core completion pulse and read data
//   l_*                        loader port, same semantics as core port
//   m_en/m_we/m_addr/m_wdata   memory request;   m_rdata read return
//   busy                       FSM not in IDLE
//   grant_id                   owner of current/last transaction (0 core)
// ---------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int RD_LAT   = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          c_valid,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_ready,
  output logic          c_rsp,
  output logic [DW-1:0] c_rdata,
  input  logic          l_valid,
  input  logic          l_we,
  input  logic [AW-1:0] l_addr,
  input  logic [DW-1:0] l_wdata,
  output logic          l_ready,
  output logic          l_rsp,
  output logic [DW-1:0] l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_wdata,
  input  logic [DW-1:0] m_rdata,
  output logic          busy,
  output logic          grant_id
);

  arb_state_t          state_q, state_d;
  logic [LAT_W-1:0]    lat_q, lat_d;
  logic [STARVE_W-1:0] starve_q, starve_d;
  logic                grant_q, grant_d;
  logic                we_q, we_d;
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [DW-1:0]       c_rdata_q, c_rdata_d;
  logic [DW-1:0]       l_rdata_q, l_rdata_d;

  logic win_valid;
  logic win_id;

  mem_arb_select #(
    .MAX_WAIT (MAX_WAIT)
  ) u_select (
    .c_valid_i    (c_valid),
    .l_valid_i    (l_valid),
    .starve_cnt_i (starve_q),
    .grant_id_i   (grant_q),
    .win_valid_o  (win_valid),
    .win_id_o     (win_id)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lat_q     <= '0;
      starve_q  <= '0;
      grant_q   <= REQ_CORE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      c_rdata_q <= '0;
      l_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      lat_q     <= lat_d;
      starve_q  <= starve_d;
      grant_q   <= grant_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      c_rdata_q <= c_rdata_d;
      l_rdata_q <= l_rdata_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    lat_d     = lat_q;
    starve_d  = starve_q;
    grant_d   = grant_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    c_rdata_d = c_rdata_q;
    l_rdata_d = l_rdata_q;

    case (state_q)
      IDLE: begin
        // win_valid means the winner is valid and sees ready: a transfer.
        if (win_valid) begin
          state_d = ACCESS;
          grant_d = win_id;
          if (win_id == REQ_LOAD) begin
            we_d     = l_we;
            addr_d   = l_addr;
            wdata_d  = l_wdata;
            starve_d = '0;
          end else begin
            we_d    = c_we;
            addr_d  = c_addr;
            wdata_d = c_wdata;
            if (l_valid && (starve_q != STARVE_W'(MAX_WAIT))) begin
              starve_d = starve_q + STARVE_W'(1);
            end
          end
        end
      end
      ACCESS: begin
        if (we_q) begin
          state_d = RESP;
        end else begin
          state_d = WAIT;
          lat_d   = LAT_W'(RD_LAT);
        end
      end
      WAIT: begin
        // Count == 1 is the cycle in which m_rdata is valid.
        if (lat_q == LAT_W'(1)) begin
          state_d = RESP;
          if (grant_q == REQ_LOAD) begin
            l_rdata_d = m_rdata;
          end else begin
            c_rdata_d = m_rdata;
          end
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign c_ready  = (state_q == IDLE) && win_valid && (win_id == REQ_CORE);
  assign l_ready  = (state_q == IDLE) && win_valid && (win_id == REQ_LOAD);

  assign m_en     = (state_q == ACCESS);
  assign m_we     = m_en && we_q;
  assign m_addr   = addr_q;
  assign m_wdata  = wdata_q;

  assign c_rsp    = (state_q == RESP) && (grant_q == REQ_CORE);
  assign l_rsp    = (state_q == RESP) && (grant_q == REQ_LOAD);
  assign c_rdata  = c_rdata_q;
  assign l_rdata  = l_rdata_q;

  assign busy     = (state_q != IDLE);
  assign grant_id = grant_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (RD_LAT=2, MAX_WAIT=4). A small memory
// model returns mem_val(addr) exactly RD_LAT cycles after a read strobe and
// a poison value otherwise. Inputs change 1 ns after the rising edge,
// outputs are sampled 2 ns after it.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int RD_LAT = 2;
  localparam int MAXW   = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          c_valid, c_we, c_ready, c_rsp;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          l_valid, l_we, l_ready, l_rsp;
  logic [AW-1:0] l_addr;
  logic [DW-1:0] l_wdata, l_rdata;
  logic          m_en, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;
  logic          busy, grant_id;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .AW (AW), .DW (DW), .RD_LAT (RD_LAT), .MAX_WAIT (MAXW)
  ) dut (
    .clk (clk), .reset (reset),
    .c_valid (c_valid), .c_we (c_we), .c_addr (c_addr), .c_wdata (c_wdata),
    .c_ready (c_ready), .c_rsp (c_rsp), .c_rdata (c_rdata),
    .l_valid (l_valid), .l_we (l_we), .l_addr (l_addr), .l_wdata (l_wdata),
    .l_ready (l_ready), .l_rsp (l_rsp), .l_rdata (l_rdata),
    .m_en (m_en), .m_we (m_we), .m_addr (m_addr), .m_wdata (m_wdata),
    .m_rdata (m_rdata), .busy (busy), .grant_id (grant_id)
  );

  function automatic logic [31:0] mem_val(input logic [31:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : {a[15:0], 16'hC0DE};
  endfunction

  bit          pipe_v [RD_LAT];
  logic [31:0] pipe_d [RD_LAT];

  always @(posedge clk) begin
    pipe_v[0] <= m_en & ~m_we;
    pipe_d[0] <= mem_val(m_addr);
    for (int i = 1; i < RD_LAT; i++) begin
      pipe_v[i] <= pipe_v[i-1];
      pipe_d[i] <= pipe_d[i-1];
    end
  end

  assign m_rdata = pipe_v[RD_LAT-1] ? pipe_d[RD_LAT-1] : 32'hBADBAD00;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered 1 ns after an edge with the arbiter idle; returns in the RESP cycle.
  task automatic run_txn(input string tag, input bit port, input bit we,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] exp_rd);
    int lat;
    if (port) begin
      l_valid = 1'b1; l_we = we; l_addr = addr; l_wdata = wdata;
    end else begin
      c_valid = 1'b1; c_we = we; c_addr = addr; c_wdata = wdata;
    end
    #1;
    check({tag, "_ready"}, port ? l_ready : c_ready, 1);
    check({tag, "_other_ready"}, port ? c_ready : l_ready, 0);
    tick();
    c_valid = 1'b0; l_valid = 1'b0;
    #1;
    check({tag, "_m_en"}, m_en, 1);
    check({tag, "_m_we"}, m_we, we);
    check({tag, "_m_addr"}, m_addr, addr);
    if (we) check({tag, "_m_wdata"}, m_wdata, wdata);
    check({tag, "_grant"}, grant_id, port);
    lat = we ? 2 : 2 + RD_LAT;
    for (int i = 2; i <= lat; i++) begin
      tick();
      #1;
      check($sformatf("%s_rsp_T%0d", tag, i), port ? l_rsp : c_rsp, (i == lat));
      check($sformatf("%s_xrsp_T%0d", tag, i), port ? c_rsp : l_rsp, 0);
    end
    check({tag, "_rdata"}, port ? l_rdata : c_rdata, exp_rd);
  endtask

  bit wins [10];
  int n_arb;

  initial begin
    reset   = 1'b1;
    c_valid = 1'b0; c_we = 1'b0; c_addr = '0; c_wdata = '0;
    l_valid = 1'b0; l_we = 1'b0; l_addr = '0; l_wdata = '0;
    repeat (2) tick();
    #1;
    check("rst_m_en", m_en, 0);
    check("rst_m_we", m_we, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_c_rsp", c_rsp, 0);
    check("rst_l_rsp", l_rsp, 0);
    check("rst_c_rdata", c_rdata, 0);
    check("rst_l_rdata", l_rdata, 0);
    check("rst_busy", busy, 0);
    check("rst_grant", grant_id, 0);
    reset = 1'b0;

    // Core read, then loader write, then core read accepted at T+3.
    tick();
    run_txn("c_rd100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);
    tick();
    run_txn("l_wr40", 1'b1, 1'b1, 32'h40, 32'h12345678, 32'h0);
    tick();
    run_txn("c_rd104", 1'b0, 1'b0, 32'h104, 32'h0, 32'h0104C0DE);

    // Core request while busy with a loader read; payload changes while stalled.
    tick();
    l_valid = 1'b1; l_we = 1'b0; l_addr = 32'h200;
    #1;
    check("stall_l_ready", l_ready, 1);
    tick();
    l_valid = 1'b0;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h300;
    #1;
    check("stall_c_ready_access", c_ready, 0);
    check("stall_m_addr_access", m_addr, 32'h200);
    tick();
    c_addr = 32'h304;
    #1;
    check("stall_c_ready_wait1", c_ready, 0);
    check("stall_m_en_wait1", m_en, 0);
    check("stall_m_addr_hold", m_addr, 32'h200);
    tick();
    #1;
    check("stall_c_ready_wait2", c_ready, 0);
    tick();
    c_addr = 32'h308;
    #1;
    check("stall_c_ready_resp", c_ready, 0);
    check("stall_l_rsp", l_rsp, 1);
    check("stall_l_rdata", l_rdata, 32'h0200C0DE);
    check("stall_c_rdata_hold", c_rdata, 32'h0104C0DE);
    tick();
    #1;
    check("stall_c_ready_idle", c_ready, 1);
    tick();
    c_valid = 1'b0;
    #1;
    check("stall_m_en", m_en, 1);
    check("stall_m_addr_latched", m_addr, 32'h308);
    repeat (3) tick();
    #1;
    check("stall_c_rsp", c_rsp, 1);
    check("stall_c_rdata", c_rdata, 32'h0308C0DE);

    // Both ports valid continuously: record the winner of 10 arbitrations.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h100;
    l_valid = 1'b1; l_we = 1'b1; l_addr = 32'h80; l_wdata = 32'h55;
    n_arb = 0;
    for (int cyc = 0; cyc < 200 && n_arb < 10; cyc++) begin
      #1;
      if (c_ready || l_ready) begin
        check("arb_one_ready", c_ready & l_ready, 0);
        wins[n_arb] = l_ready;
        n_arb++;
      end
      tick();
    end
    check("arb_count", n_arb, 10);
    for (int i = 0; i < 10; i++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      check($sformatf("arb_win%0d", i), wins[i], (i % 2 == 0));
`else
      check($sformatf("arb_win%0d", i), wins[i], (i % 5 == 4));
`endif
    end
    c_valid = 1'b0; l_valid = 1'b0;
    #1;
    for (int k = 0; k < 20 && busy; k++) begin
      tick();
      #1;
    end
    check("arb_drain_idle", busy, 0);

    // Reset while a core read sits in WAIT.
    tick();
    c_valid = 1'b1; c_we = 1'b0; c_addr = 32'h104;
    #1;
    check("rw_ready", c_ready, 1);
    tick();
    c_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("rw_busy", busy, 0);
    check("rw_c_rsp", c_rsp, 0);
    check("rw_l_rsp", l_rsp, 0);
    check("rw_m_en", m_en, 0);
    check("rw_m_we", m_we, 0);
    check("rw_m_addr", m_addr, 0);
    check("rw_m_wdata", m_wdata, 0);
    check("rw_c_rdata", c_rdata, 0);
    check("rw_l_rdata", l_rdata, 0);
    check("rw_grant", grant_id, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      #1;
      check($sformatf("rw_no_rsp%0d", i), c_rsp | l_rsp | busy, 0);
    end
    tick();
    run_txn("rw_c_rd100", 1'b0, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
